// File: rtl/m_imem_fetch.sv
// Instruction-fetch initiator for the multi-cycle instruction DRAM: one request in flight,
// 2-entry output queue toward decode, branch redirect with stale-response drop, sticky timeout.
//  state | meaning
//  IDLE  | queue full or post-reset holdoff running
//  REQ   | read strobe issued at fetch pc
//  WAIT  | waiting for the DRAM response strobe
//  ERR   | response never arrived; only reset exits
module m_imem_fetch #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter int          TIMEOUT  = 16
) (
   input  logic        w_clock,
   input  logic        w_reset,
   input  logic        w_redirect,
   input  logic [31:0] w_target,
   input  logic        w_ready,
   input  logic [31:0] w_mem_insn,
   input  logic        w_mem_oe,
   output logic [31:0] r_mem_pc,
   output logic        r_mem_re,
   output logic        r_valid,
   output logic [31:0] r_insn,
   output logic [31:0] r_pc,
   output logic        r_timeout
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ERR} state_t;

   localparam int          CW  = $clog2(TIMEOUT + 1);
   localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

   state_t      state, state_n;
   logic [31:0] pc, mem_pc;
   logic        drop;
   logic [CW-1:0] cnt;
   logic [2:0]  holdoff;
   logic [1:0]  count, count_n;
   logic [31:0] q_insn [2];
   logic [31:0] q_pc   [2];
   logic        push, pop, flush;

   assign flush = w_redirect && (state != S_ERR);
   assign push  = (state == S_WAIT) && w_mem_oe && !drop && !w_redirect;
   assign pop   = r_valid && w_ready && !w_redirect;

   always_comb begin
      count_n = count;
      if (flush)
         count_n = 2'd0;
      else
         count_n = 2'(count + {1'b0, push} - {1'b0, pop});
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE: if (flush || (count < 2'd2 && holdoff == 3'd0)) state_n = S_REQ;
         S_REQ:  state_n = S_WAIT;
         S_WAIT: begin
            if (w_mem_oe)
               state_n = (count_n < 2'd2) ? S_REQ : S_IDLE;
            else if (cnt == CW'(TIMEOUT - 1))
               state_n = S_ERR;
         end
         S_ERR:  state_n = S_ERR;
      endcase
   end

   always_ff @(posedge w_clock) begin
      if (w_reset) begin
         state     <= S_IDLE;
         pc        <= PC0;
         mem_pc    <= '0;
         drop      <= 1'b0;
         cnt       <= '0;
         holdoff   <= 3'd4;
         count     <= 2'd0;
         q_insn[0] <= '0;
         q_insn[1] <= '0;
         q_pc[0]   <= '0;
         q_pc[1]   <= '0;
      end else begin
         state <= state_n;
         count <= count_n;
         if (holdoff != 3'd0) holdoff <= holdoff - 3'd1;
         if (state == S_REQ) begin
            mem_pc <= pc;
            cnt    <= '0;
         end else if (state == S_WAIT) begin
            cnt <= CW'(cnt + 1'b1);
         end
         if (state == S_WAIT && w_mem_oe && drop) drop <= 1'b0;
         // a redirect landing on the oe cycle discards that word itself, so no drop needed
         if (flush) begin
            pc <= {w_target[31:2], 2'b00};
            if (state == S_REQ || (state == S_WAIT && !w_mem_oe)) drop <= 1'b1;
         end else if (push) begin
            pc <= pc + 32'd4;
         end
         if (push && pop) begin
            if (count == 2'd2) begin
               q_insn[0] <= q_insn[1];
               q_pc[0]   <= q_pc[1];
               q_insn[1] <= w_mem_insn;
               q_pc[1]   <= pc;
            end else begin
               q_insn[0] <= w_mem_insn;
               q_pc[0]   <= pc;
            end
         end else if (pop) begin
            q_insn[0] <= q_insn[1];
            q_pc[0]   <= q_pc[1];
         end else if (push) begin
            if (count == 2'd0) begin
               q_insn[0] <= w_mem_insn;
               q_pc[0]   <= pc;
            end else begin
               q_insn[1] <= w_mem_insn;
               q_pc[1]   <= pc;
            end
         end
      end
   end

   assign r_mem_re  = (state == S_REQ);
   assign r_mem_pc  = (state == S_REQ) ? pc : mem_pc;
   assign r_valid   = (count != 2'd0) && (state != S_ERR);
   assign r_insn    = q_insn[0];
   assign r_pc      = q_pc[0];
   assign r_timeout = (state == S_ERR);
endmodule

// File: tb/tb_m_imem_fetch.sv
// Bench for m_imem_fetch: 5-cycle DRAM model (re in N -> oe in N+4), directed vectors
// and hand-timed sequences for stall, redirect, timeout and mid-request reset.
module tb_m_imem_fetch;
   logic        w_clock = 1'b0;
   logic        w_reset = 1'b1;
   logic        w_redirect = 1'b0;
   logic [31:0] w_target = '0;
   logic        w_ready = 1'b1;
   logic [31:0] w_mem_insn;
   logic        w_mem_oe;
   logic [31:0] r_mem_pc;
   logic        r_mem_re;
   logic        r_valid;
   logic [31:0] r_insn;
   logic [31:0] r_pc;
   logic        r_timeout;

   m_imem_fetch #(.RESET_PC(32'd0), .TIMEOUT(16)) dut (
      .w_clock(w_clock), .w_reset(w_reset), .w_redirect(w_redirect), .w_target(w_target),
      .w_ready(w_ready), .w_mem_insn(w_mem_insn), .w_mem_oe(w_mem_oe),
      .r_mem_pc(r_mem_pc), .r_mem_re(r_mem_re), .r_valid(r_valid), .r_insn(r_insn),
      .r_pc(r_pc), .r_timeout(r_timeout)
   );

   always #5 w_clock = ~w_clock;

   // DRAM model: word k holds 11*(k+1), so mem[0..3] = 11,22,33,44
   logic        oe_en = 1'b1;
   logic [3:0]  pv = '0;
   logic [31:0] pa [4];
   always @(posedge w_clock) begin
      pv    <= {pv[2:0], r_mem_re === 1'b1};
      pa[0] <= r_mem_pc;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
   end
   assign w_mem_oe   = pv[3] & oe_en;
   assign w_mem_insn = w_mem_oe ? 32'(11 * (pa[3][31:2] + 1)) : 32'd0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge w_clock);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic do_reset();
      w_reset    = 1'b1;
      w_redirect = 1'b0;
      tick();
      tick();
      w_reset = 1'b0;
      cyc     = 0;
   endtask

   typedef struct {
      int          c;
      logic        re;
      logic [31:0] mpc;
      logic        v;
      logic [31:0] insn;
      logic [31:0] pc;
   } vec_t;

   vec_t vec [11];

   initial begin
      int j;
      int vcnt;
      int recnt;

      vec[0]  = '{0,  1'b0, 32'd0,  1'b0, 32'd0,  32'd0};
      vec[1]  = '{4,  1'b0, 32'd0,  1'b0, 32'd0,  32'd0};
      vec[2]  = '{5,  1'b1, 32'd0,  1'b0, 32'd0,  32'd0};
      vec[3]  = '{6,  1'b0, 32'd0,  1'b0, 32'd0,  32'd0};
      vec[4]  = '{9,  1'b0, 32'd0,  1'b0, 32'd0,  32'd0};
      vec[5]  = '{10, 1'b1, 32'd4,  1'b1, 32'd11, 32'd0};
      vec[6]  = '{11, 1'b0, 32'd4,  1'b0, 32'd0,  32'd0};
      vec[7]  = '{15, 1'b1, 32'd8,  1'b1, 32'd22, 32'd4};
      vec[8]  = '{20, 1'b1, 32'd12, 1'b1, 32'd33, 32'd8};
      vec[9]  = '{25, 1'b1, 32'd16, 1'b1, 32'd44, 32'd12};
      vec[10] = '{26, 1'b0, 32'd16, 1'b0, 32'd0,  32'd0};

      // reset state
      repeat (6) tick();
      chk("rst_re", r_mem_re, 0);
      chk("rst_mem_pc", r_mem_pc, 0);
      chk("rst_valid", r_valid, 0);
      chk("rst_insn", r_insn, 0);
      chk("rst_pc", r_pc, 0);
      chk("rst_timeout", r_timeout, 0);

      // streaming fetch, w_ready=1
      w_ready = 1'b1;
      do_reset();
      j = 0;
      vcnt = 0;
      for (int c = 0; c <= 26; c++) begin
         run_to(c);
         if (r_valid === 1'b1) vcnt++;
         if (j < 11 && vec[j].c == c) begin
            chk($sformatf("stream_re_c%0d", c), r_mem_re, vec[j].re);
            chk($sformatf("stream_mpc_c%0d", c), r_mem_pc, vec[j].mpc);
            chk($sformatf("stream_valid_c%0d", c), r_valid, vec[j].v);
            if (vec[j].v) begin
               chk($sformatf("stream_insn_c%0d", c), r_insn, vec[j].insn);
               chk($sformatf("stream_pc_c%0d", c), r_pc, vec[j].pc);
            end
            j++;
         end
      end
      chk("stream_valid_cycles", vcnt, 4);

      // stall: w_ready=0 fills the queue with two words, then no more requests
      w_ready = 1'b0;
      do_reset();
      recnt = 0;
      for (int c = 0; c <= 30; c++) begin
         run_to(c);
         if (r_mem_re === 1'b1) recnt++;
      end
      chk("stall_req_count", recnt, 2);
      chk("stall_valid", r_valid, 1);
      chk("stall_insn", r_insn, 11);
      chk("stall_pc", r_pc, 0);
      w_ready = 1'b1;
      run_to(31);
      chk("unstall_insn2", r_insn, 22);
      chk("unstall_pc2", r_pc, 4);
      run_to(32);
      chk("unstall_re", r_mem_re, 1);
      chk("unstall_mem_pc", r_mem_pc, 8);
      chk("unstall_empty", r_valid, 0);
      run_to(37);
      chk("resume_valid", r_valid, 1);
      chk("resume_insn", r_insn, 33);
      chk("resume_pc", r_pc, 8);

      // redirect to 12 while waiting on pc 4
      do_reset();
      run_to(12);
      w_redirect = 1'b1;
      w_target   = 32'd12;
      tick();
      w_redirect = 1'b0;
      vcnt = 0;
      for (int c = 13; c <= 19; c++) begin
         run_to(c);
         if (r_valid === 1'b1) vcnt++;
         if (c == 15) begin
            chk("redir_wait_re", r_mem_re, 1);
            chk("redir_wait_mem_pc", r_mem_pc, 12);
         end
      end
      chk("redir_wait_no_stale", vcnt, 0);
      run_to(20);
      chk("redir_wait_valid", r_valid, 1);
      chk("redir_wait_insn", r_insn, 44);
      chk("redir_wait_pc", r_pc, 12);

      // redirect to 13 in the oe cycle of pc 0
      do_reset();
      run_to(9);
      chk("redir_oe_oe_seen", w_mem_oe, 1);
      w_redirect = 1'b1;
      w_target   = 32'd13;
      tick();
      w_redirect = 1'b0;
      chk("redir_oe_empty", r_valid, 0);
      chk("redir_oe_re", r_mem_re, 1);
      chk("redir_oe_mem_pc", r_mem_pc, 12);
      run_to(15);
      chk("redir_oe_valid", r_valid, 1);
      chk("redir_oe_insn", r_insn, 44);
      chk("redir_oe_pc", r_pc, 12);

      // timeout with oe tied low: WAIT entered at cycle 6
      oe_en = 1'b0;
      do_reset();
      run_to(21);
      chk("tmo_early", r_timeout, 0);
      run_to(22);
      chk("tmo_set", r_timeout, 1);
      chk("tmo_valid", r_valid, 0);
      recnt = 0;
      for (int c = 23; c <= 40; c++) begin
         run_to(c);
         if (r_mem_re === 1'b1) recnt++;
      end
      chk("tmo_no_req", recnt, 0);
      chk("tmo_sticky", r_timeout, 1);
      oe_en = 1'b1;
      do_reset();
      chk("tmo_cleared", r_timeout, 0);
      run_to(5);
      chk("tmo_refetch_re", r_mem_re, 1);
      chk("tmo_refetch_pc", r_mem_pc, 0);
      run_to(10);
      chk("tmo_refetch_insn", r_insn, 11);

      // reset while waiting on pc 8
      do_reset();
      run_to(17);
      chk("midrst_pre_mem_pc", r_mem_pc, 8);
      w_reset = 1'b1;
      tick();
      chk("midrst_re", r_mem_re, 0);
      chk("midrst_mem_pc", r_mem_pc, 0);
      chk("midrst_valid", r_valid, 0);
      chk("midrst_insn", r_insn, 0);
      chk("midrst_pc", r_pc, 0);
      chk("midrst_timeout", r_timeout, 0);
      w_reset = 1'b0;
      cyc = 0;
      vcnt = 0;
      for (int c = 1; c <= 9; c++) begin
         run_to(c);
         if (r_valid === 1'b1) vcnt++;
      end
      chk("midrst_no_stale", vcnt, 0);
      run_to(10);
      chk("midrst_valid_after", r_valid, 1);
      chk("midrst_first_insn", r_insn, 11);
      chk("midrst_first_pc", r_pc, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
